// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing
// over a shared memory with ready handshake, timeout and illegal-op traps.
module controle_multiciclo #(
    parameter int MEM_HANDSHAKE  = 1,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_READ,
        S_MEM_WRITE, S_WB_ALU, S_WB_MEM, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    state_t           w_dec;
    logic [7:0]       r_wait;
    logic             r_trap;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_instret;
    logic             w_ready;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_retire;
    logic             w_r_ok;
    logic             w_i_ok;
    logic [3:0]       w_alu_r;

    assign w_ready   = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ)
                    || (r_state == S_MEM_WRITE);
    assign w_timeout = w_waiting && !w_ready && (r_wait == WAIT_LAST);

    assign w_r_ok = ((funct3 == 3'b000)
                     && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)))
                 || (((funct3 == 3'b111) || (funct3 == 3'b110)
                      || (funct3 == 3'b101)) && (funct7 == 7'b0000000));
    assign w_i_ok = (funct3 == 3'b000) || (funct3 == 3'b111)
                 || (funct3 == 3'b110);

    // Legality is fully resolved here so execute states never see a bad op
    always_comb begin
        w_dec = S_TRAP;
        unique case (opcode)
            OP_R:    if (w_r_ok) w_dec = S_EXEC_R;
            OP_I:    if (w_i_ok) w_dec = S_EXEC_I;
            OP_LD,
            OP_ST:   if (funct3 == 3'b001) w_dec = S_MEM_ADDR;
            OP_BR:   if (funct3 == 3'b000) w_dec = S_BRANCH;
            default: w_dec = S_TRAP;
        endcase
    end

    always_comb begin
        w_alu_r = ALU_ADD;
        unique case (funct3)
            3'b000:  w_alu_r = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b111:  w_alu_r = ALU_AND;
            3'b110:  w_alu_r = ALU_OR;
            3'b101:  w_alu_r = ALU_SRL;
            default: w_alu_r = ALU_ADD;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (w_ready)        w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE:   w_next = w_dec;
            S_EXEC_R,
            S_EXEC_I:   w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (opcode == OP_ST) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (w_ready)        w_next = S_WB_MEM;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WRITE: begin
                if (w_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB_ALU,
            S_WB_MEM,
            S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= 8'd0;
            r_instret <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            r_state <= w_next;
            // Counter restarts whenever a waiting state is (re)entered
            r_wait  <= (w_waiting && (w_next == r_state)) ? r_wait + 8'd1 : 8'd0;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap  <= 1'b1;
                r_cause <= (r_state == S_DECODE) ? 2'b01 : 2'b10;
            end
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_control   = ALU_AND;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    ir_write    = w_ready;
                    pc_write    = w_ready;
                end
                S_DECODE: begin
                    alu_src_a   = 2'b01;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a   = 2'b10;
                    alu_control = w_alu_r;
                end
                S_EXEC_I: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b10;
                    alu_control = (funct3 == 3'b000) ? ALU_ADD : w_alu_r;
                end
                S_MEM_ADDR: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b10;
                    alu_control   = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                end
                S_TRAP:  mem_req = 1'b0;
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign instret    = r_instret;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed scenarios plus random instruction
// streams checked against an instruction-level timing/behaviour model.
module tb_controle_multiciclo;

    localparam int T  = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // cls: 0 R-type, 1 I-imm, 2 load, 3 store, 4 branch
    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       f7any;
        logic [2:0] cls;
        logic [3:0] alu;
    } pat_t;

    typedef struct packed {
        int cycles; int memreq; int irw; int pcw; int regw; int m2r; int we;
        int pwc; int pcs; int execn; int aluop; int trap; int cause;
        int instret;
    } stat_t;

    pat_t pats [11] = '{
        '{OP_R,  3'b000, 7'h00, 1'b0, 3'd0, 4'b0010},
        '{OP_R,  3'b000, 7'h20, 1'b0, 3'd0, 4'b0100},
        '{OP_R,  3'b111, 7'h00, 1'b0, 3'd0, 4'b0000},
        '{OP_R,  3'b110, 7'h00, 1'b0, 3'd0, 4'b0001},
        '{OP_R,  3'b101, 7'h00, 1'b0, 3'd0, 4'b0101},
        '{OP_I,  3'b000, 7'h00, 1'b1, 3'd1, 4'b0010},
        '{OP_I,  3'b111, 7'h00, 1'b1, 3'd1, 4'b0000},
        '{OP_I,  3'b110, 7'h00, 1'b1, 3'd1, 4'b0001},
        '{OP_LD, 3'b001, 7'h00, 1'b1, 3'd2, 4'b0010},
        '{OP_ST, 3'b001, 7'h00, 1'b1, 3'd3, 4'b0010},
        '{OP_BR, 3'b000, 7'h00, 1'b1, 3'd4, 4'b0100}
    };

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = 7'h0;
    logic [2:0]    funct3 = 3'h0;
    logic [6:0]    funct7 = 7'h0;
    logic          mem_ready = 1'b1;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic          pc_write_cond, pc_source, reg_write, mem_to_reg, trap;
    logic [1:0]    alu_src_a, alu_src_b, trap_cause;
    logic [3:0]    alu_control;
    logic [CW-1:0] instret;
    logic [16:0]   ctrl;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    int fw_left = 0;
    int mw_left = 0;

    controle_multiciclo #(
        .MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(T), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    assign ctrl = {mem_req, mem_we, i_or_d, ir_write, pc_write,
                   pc_write_cond, pc_source, alu_src_a, alu_src_b,
                   alu_control, reg_write, mem_to_reg};

    always #5 clk = ~clk;

    // Instruction-level expectations: waits, cycle counts, trap outcome
    function automatic stat_t model(input logic [6:0] op,
                                    input logic [2:0] f3,
                                    input logic [6:0] f7,
                                    input int fw, input int mw, input int cnt);
        stat_t e;
        int cls;
        int alu;
        int mp;
        e = '0;
        cls = -1;
        alu = 0;
        foreach (pats[i])
            if (pats[i].op == op && pats[i].f3 == f3
                && (pats[i].f7any || pats[i].f7 == f7)) begin
                cls = int'(pats[i].cls);
                alu = int'(pats[i].alu);
            end
        e.instret = cnt;
        if (fw >= T) begin
            e.cycles = T; e.memreq = T; e.trap = 1; e.cause = 2;
            return e;
        end
        e.cycles = fw + 2; e.memreq = fw + 1; e.irw = 1; e.pcw = 1;
        if (cls < 0) begin
            e.trap = 1; e.cause = 1;
            return e;
        end
        e.execn = 1;
        e.aluop = alu;
        if (cls <= 1) begin
            e.cycles += 2; e.regw = 1;
        end else if (cls == 4) begin
            e.cycles += 1; e.pwc = 1; e.pcs = 1;
        end else begin
            mp = (mw >= T) ? T : mw + 1;
            e.cycles += 1 + mp;
            e.memreq += mp;
            if (cls == 3) e.we = mp;
            if (mw >= T) begin
                e.trap = 1; e.cause = 2;
                return e;
            end
            if (cls == 2) begin
                e.cycles += 1; e.regw = 1; e.m2r = 1;
            end
        end
        e.instret = (cnt + 1) % (1 << CW);
        return e;
    endfunction

    task automatic drive_ready();
        if (mem_req && !i_or_d) begin
            mem_ready = (fw_left == 0);
            if (fw_left > 0) fw_left--;
        end else if (mem_req) begin
            mem_ready = (mw_left == 0);
            if (mw_left > 0) mw_left--;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Entry point: negedge+1 of a FETCH cycle. Exits at retire or trap.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fw,
                             input int mw, output stat_t o);
        logic [CW-1:0] start;
        opcode = op; funct3 = f3; funct7 = f7;
        fw_left = fw; mw_left = mw;
        o = '0;
        start = instret;
        for (int k = 0; k < 60; k++) begin
            if (trap || instret != start) break;
            drive_ready();
            #1;
            o.cycles++;
            o.memreq += int'(mem_req);
            o.irw    += int'(ir_write);
            o.pcw    += int'(pc_write);
            o.regw   += int'(reg_write);
            o.m2r    += int'(mem_to_reg);
            o.we     += int'(mem_we);
            o.pwc    += int'(pc_write_cond);
            o.pcs    += int'(pc_source);
            if (alu_src_a == 2'b10) begin
                o.execn++;
                o.aluop = int'(alu_control);
            end
            @(negedge clk); #1;
        end
        o.trap = int'(trap);
        o.cause = int'(trap_cause);
        o.instret = int'(instret);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        logic [16:0] fetch_ctrl;
        fetch_ctrl = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                      2'b00, 2'b01, 4'b0010, 1'b0, 1'b0};
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (ctrl !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", ctrl);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({trap, trap_cause, instret} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: trap %b cause %b instret %0d want 0",
                     trap, trap_cause, instret);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ctrl !== fetch_ctrl) begin
            n_fail++;
            $display("FAIL first_fetch: got %h want %h", ctrl, fetch_ctrl);
        end
        exp_cnt = 0;
    endtask

    task automatic test_sub();
        stat_t o, e;
        e = model(OP_R, 3'b000, 7'h20, 0, 0, exp_cnt);
        run_instr(OP_R, 3'b000, 7'h20, 0, 0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL sub: got %p want %p", o, e);
        end
        n_cmp++;
        if (o.cycles != 4 || o.aluop != 4 || o.instret != 1) begin
            n_fail++;
            $display("FAIL sub_direct: cyc %0d alu %0d cnt %0d want 4 4 1",
                     o.cycles, o.aluop, o.instret);
        end
        exp_cnt = e.instret;
    endtask

    task automatic test_lh_wait();
        stat_t o, e;
        logic [6:0] f7;
        f7 = 7'($urandom);
        e = model(OP_LD, 3'b001, f7, 0, 3, exp_cnt);
        run_instr(OP_LD, 3'b001, f7, 0, 3, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL lh_wait: got %p want %p", o, e);
        end
        n_cmp++;
        if (o.cycles != 8 || o.memreq != 5 || o.m2r != 1 || o.regw != 1) begin
            n_fail++;
            $display("FAIL lh_direct: cyc %0d req %0d m2r %0d want 8 5 1",
                     o.cycles, o.memreq, o.m2r);
        end
        exp_cnt = e.instret;
    endtask

    task automatic test_beq();
        stat_t o, e;
        e = model(OP_BR, 3'b000, 7'h00, 0, 0, exp_cnt);
        run_instr(OP_BR, 3'b000, 7'h00, 0, 0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL beq: got %p want %p", o, e);
        end
        n_cmp++;
        if (o.cycles != 3 || o.pwc != 1 || o.regw != 0 || o.aluop != 4) begin
            n_fail++;
            $display("FAIL beq_direct: cyc %0d pwc %0d rw %0d want 3 1 0",
                     o.cycles, o.pwc, o.regw);
        end
        exp_cnt = e.instret;
    endtask

    task automatic test_illegal();
        stat_t o, e;
        e = model(7'b1101111, 3'b000, 7'h00, 0, 0, exp_cnt);
        run_instr(7'b1101111, 3'b000, 7'h00, 0, 0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL illegal: got %p want %p", o, e);
        end
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (ctrl !== '0 || trap !== 1'b1 || trap_cause !== 2'b01
                || int'(instret) != exp_cnt) begin
                n_fail++;
                $display("FAIL trap_hold: ctrl %h trap %b cause %b cnt %0d",
                         ctrl, trap, trap_cause, instret);
            end
            @(negedge clk); #1;
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        stat_t o, e;
        e = model(OP_I, 3'b000, 7'h00, T, 0, exp_cnt);
        run_instr(OP_I, 3'b000, 7'h00, T, 0, o);
        n_cmp++;
        if (o !== e || o.cause != 2 || o.cycles != T) begin
            n_fail++; $display("FAIL fetch_timeout: got %p want %p", o, e);
        end
        apply_reset();
        e = model(OP_I, 3'b000, 7'h00, T - 1, 0, exp_cnt);
        run_instr(OP_I, 3'b000, 7'h00, T - 1, 0, o);
        n_cmp++;
        if (o !== e || o.trap != 0) begin
            n_fail++; $display("FAIL ready_last_cycle: got %p want %p", o, e);
        end
        exp_cnt = e.instret;
        e = model(OP_LD, 3'b001, 7'h00, 0, T, exp_cnt);
        run_instr(OP_LD, 3'b001, 7'h00, 0, T, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL mem_timeout: got %p want %p", o, e);
        end
        apply_reset();
        e = model(OP_ST, 3'b001, 7'h00, 1, T - 1, exp_cnt);
        run_instr(OP_ST, 3'b001, 7'h00, 1, T - 1, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL sh_long_wait: got %p want %p", o, e);
        end
        exp_cnt = e.instret;
    endtask

    task automatic test_back_to_back();
        stat_t o, e;
        int fw, mw;
        logic [6:0] f7;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            fw = $urandom_range(0, T - 1);
            mw = $urandom_range(0, T - 1);
            f7 = 7'($urandom);
            e = model(OP_I, 3'b111, f7, fw, mw, exp_cnt);
            run_instr(OP_I, 3'b111, f7, fw, mw, o);
            n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL andi_%0d: got %p want %p", i, o, e);
            end
            exp_cnt = e.instret;
        end
        n_cmp++;
        if (instret !== '0) begin
            n_fail++; $display("FAIL instret_wrap: got %0d want 0", instret);
        end
    endtask

    task automatic test_reset_mid();
        stat_t o;
        bit found;
        apply_reset();
        run_instr(OP_I, 3'b000, 7'h00, 0, 0, o);
        run_instr(OP_I, 3'b110, 7'h00, 0, 0, o);
        opcode = OP_I; funct3 = 3'b111; funct7 = 7'h00;
        fw_left = 0; mw_left = 0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            drive_ready();
            #1;
            if (alu_src_a == 2'b10 && alu_src_b == 2'b10) begin
                found = 1;
                break;
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL reach_exec_i: got none want EXEC_I");
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ctrl !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", ctrl);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || i_or_d !== 1'b0 || instret !== '0
            || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_fetch: req %b iord %b cnt %0d want 1 0 0",
                     mem_req, i_or_d, instret);
        end
        exp_cnt = 0;
    endtask

    task automatic test_random();
        stat_t o, e;
        pat_t p;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int fw, mw;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                p = pats[$urandom_range(0, 10)];
                op = p.op; f3 = p.f3;
                f7 = p.f7any ? 7'($urandom) : p.f7;
            end else begin
                op = 7'($urandom); f3 = 3'($urandom);
                f7 = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'h00;
            end
            fw = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, 3);
            e = model(op, f3, f7, fw, mw, exp_cnt);
            run_instr(op, f3, f7, fw, mw, o);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rand_%0d op %b f3 %b f7 %b fw %0d mw %0d: got %p want %p",
                         i, op, f3, f7, fw, mw, o, e);
            end
            if (e.trap != 0) begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if (ctrl !== '0 || trap !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_trap_hold_%0d: ctrl %h trap %b want 0 1",
                             i, ctrl, trap);
                end
                apply_reset();
            end else begin
                exp_cnt = e.instret;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_lh_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control FSM for the RISC-V core. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory with a ready handshake. It replaces the single-cycle main control and ALU control pair for the multicycle datapath, and adds these behaviours: `add`, `and`, `addi` and `ori` decode; bounded memory-wait timeout; illegal-instruction trap; retired-instruction counter.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = wait on `mem_ready`; 0 = memory is single-cycle and `mem_ready` is ignored (treated as 1).
- `TIMEOUT_CYCLES`, default 15: maximum consecutive cycles waiting on `mem_ready` before trap; range 1..255.
- `CNT_W`, default 32: width of `instret`.
- Clock, reset: one clock; reset is synchronous and active-high.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: IR[6:0]; stable from DECODE onward.
- `funct3` input 3: IR[14:12].
- `funct7` input 7: IR[31:25].
- `mem_ready` input 1: memory completed the current request this cycle.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: request is a write (halfword store).
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load IR and old-PC register.
- `pc_write` output 1: unconditional PC write.
- `pc_write_cond` output 1: PC write when ALU zero.
- `pc_source` output 1: 0 = ALU result, 1 = ALUOut.
- `alu_src_a` output 2: 00 = PC, 01 = old PC, 10 = reg A.
- `alu_src_b` output 2: 00 = reg B, 01 = constant 4, 10 = immediate.
- `alu_control` output 4: AND 0000, OR 0001, ADD 0010, SUB 0100, SRL 0101.
- `reg_write` output 1: register-file write.
- `mem_to_reg` output 1: writeback select; 0 = ALUOut, 1 = MDR.
- `trap` output 1: FSM halted in TRAP.
- `trap_cause` output 2: 00 none, 01 illegal instruction, 10 memory timeout.
- `instret` output CNT_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WRITE, WB_ALU, WB_MEM, BRANCH, TRAP. Outputs are Moore, decoded from state and IR fields. Any output not listed for a state is 0.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, ADD.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=10, ADD (branch target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - anything else → TRAP, cause 01
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00. ALU op by funct3/funct7:
  - 000/0000000 ADD; 000/0100000 SUB
  - 111/0000000 AND; 110/0000000 OR
  - 101/0000000 SRL
  - any other combination → TRAP, cause 01 (checked in DECODE; EXEC_R is never entered).
- EXEC_I: `alu_src_a`=10, `alu_src_b`=10. funct3 000 → ADD, 111 → AND, 110 → OR; any other funct3 → TRAP, cause 01 (checked in DECODE).
- Loads/stores: load requires funct3=001 (lh) and store requires funct3=001 (sh); otherwise TRAP.
- Branches: beq only, funct3=000; otherwise TRAP.
- MEM_ADDR: `alu_src_a`=10, `alu_src_b`=10, ADD. Next state MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: `mem_req`=1, `i_or_d`=1. On `mem_ready` → WB_MEM.
- MEM_WRITE: `mem_req`=1, `mem_we`=1, `i_or_d`=1. On `mem_ready` → FETCH (retire).
- WB_ALU: `reg_write`=1, `mem_to_reg`=0 → FETCH (retire).
- WB_MEM: `reg_write`=1, `mem_to_reg`=1 → FETCH (retire).
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, SUB, `pc_write_cond`=1, `pc_source`=1 → FETCH (retire).
- TRAP: all control outputs 0, `trap`=1, `trap_cause` held. The FSM leaves TRAP only via `reset`.
- Wait counter (8-bit):
  - Clears on entry to any waiting state (FETCH, MEM_READ, MEM_WRITE).
  - Increments each cycle in a waiting state with `mem_ready`=0.
  - If `mem_ready`=0 and the counter equals TIMEOUT_CYCLES-1 → TRAP, cause 10.
  - `mem_ready`=1 on that same cycle takes priority: completes normally, no trap.
  - The counter is unused when MEM_HANDSHAKE=0.
- `instret` increments by 1 on each retire transition and wraps modulo 2^CNT_W. It does not increment on entry to TRAP.

## Timing
- Reset:
  - State ← FETCH, wait counter ← 0, `instret` ← 0, `trap` ← 0, `trap_cause` ← 00.
  - While `reset`=1, all control outputs are forced to 0, including `mem_req`.
  - First `mem_req` occurs in the first cycle after `reset` deasserts.
- Cycles per instruction with zero wait:
  - beq: 3
  - R-type, I-immediate, sh: 4
  - lh: 5
  - Each memory wait cycle adds 1.
- Reset asserted mid-instruction: abort, no retire, next state FETCH. Outputs are 0 in the reset cycle.
- `mem_req` is held high and the address select is held stable until `mem_ready` is sampled high. A `mem_ready` outside a waiting state is ignored.

## Test plan
- Reset, then `sub` (opcode 0110011, f3 000, f7 0100000), `mem_ready`=1 always → states FETCH, DECODE, EXEC_R, WB_ALU; `alu_control`=0100 in EXEC_R; `instret`=1 after 4 cycles.
- `lh` with `mem_ready` low for 3 cycles in MEM_READ → `mem_req` and `i_or_d` held for 4 cycles; `reg_write`=`mem_to_reg`=1 in WB_MEM; total 8 cycles.
- `beq` → 3 cycles; `pc_write_cond`=1, `pc_source`=1, SUB in BRANCH; `reg_write` never asserted.
- Opcode 1101111 → TRAP after DECODE, `trap_cause`=01; `instret` unchanged; all outputs 0 until reset.
- `mem_ready` held low in FETCH, TIMEOUT_CYCLES=4 → TRAP, cause 10, on the 4th wait cycle. Repeat with `mem_ready`=1 on that 4th cycle → normal DECODE, no trap.
- CNT_W=4, 16 back-to-back `andi` → `instret` wraps to 0; `reset` asserted during EXEC_I → FETCH next cycle, `instret`=0.
